// File: rtl/led_seq_pkg.sv
// Shared types and elaboration helpers for the LED blink-code sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_t;

    // Bits needed to hold a tick count in the range 0..ticks.
    function automatic int ticks_to_width(input int ticks);
        return (ticks < 1) ? 1 : $clog2(ticks + 1);
    endfunction

    // Clock cycles per prescaler tick.
    function automatic int calc_p(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: one-cycle tick every P cycles, restarted by a synchronous clear.
module led_tick_gen
#(
    parameter int P = 10
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int W = (P > 1) ? $clog2(P) : 1;

    logic [W-1:0] cnt;

    // Cycle counter that wraps at P-1 and returns to zero on clear.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || cnt == W'(P - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == W'(P - 1));

endmodule

// File: rtl/led_code_sequencer.sv
// Round-robin sharing of one active-low LED among N_REQ blink-code requesters.
module led_code_sequencer
    import led_seq_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1000,
    parameter int N_REQ   = 4,
    parameter int CNT_W   = 4,
    parameter int ON_T    = 200,
    parameter int OFF_T   = 200,
    parameter int GAP_T   = 1000
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] count,
    output logic [N_REQ-1:0]       gnt,
    output logic                   done,
    output logic                   busy,
    output logic                   led
);

    localparam int P     = calc_p(CLK_HZ, TICK_HZ);
    localparam int PH_W  = ticks_to_width(max3(ON_T, OFF_T, GAP_T));
    localparam int IDX_W = $clog2(N_REQ);

    if (ON_T < 1 || OFF_T < 1 || GAP_T < 1) begin : g_bad_times
        $error("led_code_sequencer: ON_T, OFF_T and GAP_T must all be >= 1");
    end
    if (TICK_HZ < 1 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_rate
        $error("led_code_sequencer: CLK_HZ must be an exact multiple of TICK_HZ");
    end
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("led_code_sequencer: N_REQ must be in 2..8");
    end

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   remaining;
    logic [PH_W-1:0]    phase_cnt;

    logic [N_REQ-1:0]   eligible;
    logic               found;
    logic [IDX_W-1:0]   sel;
    logic [N_REQ-1:0]   gnt_next;
    logic [PH_W-1:0]    limit_m1;
    logic               tick;
    logic               phase_end;
    logic               presc_clr;

    // A requester with a zero count is ignored so it cannot stall the others.
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a value held and no latch is inferred.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = req[i] && (count[i*CNT_W +: CNT_W] != '0);
        end
    end

    // Round-robin search: first eligible requester at or after rr_ptr, with wrap.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        gnt_next = '0;
        for (int off = 0; off < N_REQ; off++) begin
            int idx;
            idx = (int'(rr_ptr) + off) % N_REQ;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                sel   = IDX_W'(idx);
            end
        end
        gnt_next[sel] = found;
    end

    // Last tick index of the current phase; a phase ends on that tick.
    always_comb begin
        limit_m1 = '0;
        case (state)
            ON:      limit_m1 = PH_W'(ON_T - 1);
            OFF:     limit_m1 = PH_W'(OFF_T - 1);
            GAP:     limit_m1 = PH_W'(GAP_T - 1);
            default: limit_m1 = '0;
        endcase
    end

    assign phase_end = (state != IDLE) && tick && (phase_cnt == limit_m1);
    // Holding the prescaler cleared in IDLE makes it start fresh on every grant.
    assign presc_clr = (state == IDLE) || phase_end;

    led_tick_gen #(.P(P)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (presc_clr),
        .tick  (tick)
    );

    // Sequencer FSM: arbitration, pulse/gap timing and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            remaining <= '0;
            phase_cnt <= '0;
            gnt       <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            led       <= 1'b1;
        end else begin
            gnt  <= '0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt       <= gnt_next;
                        state     <= ON;
                        led       <= 1'b0;
                        busy      <= 1'b1;
                        remaining <= count[int'(sel)*CNT_W +: CNT_W];
                        rr_ptr    <= IDX_W'((int'(sel) + 1) % N_REQ);
                        phase_cnt <= '0;
                    end
                end
                default: begin
                    if (phase_end) begin
                        phase_cnt <= '0;
                        case (state)
                            ON: begin
                                remaining <= remaining - CNT_W'(1);
                                led       <= 1'b1;
                                state     <= (remaining != CNT_W'(1)) ? OFF : GAP;
                            end
                            OFF: begin
                                led   <= 1'b0;
                                state <= ON;
                            end
                            default: begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        endcase
                    end else if (tick) begin
                        phase_cnt <= phase_cnt + PH_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_code_sequencer.sv
// Directed bench: P=10, ON=20, OFF=30, GAP=50 cycles at the chosen parameters.
module tb_led_code_sequencer;

    localparam int ON_C  = 20;
    localparam int OFF_C = 30;
    localparam int GAP_C = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] count;
    logic [3:0]  gnt;
    logic        done;
    logic        busy;
    logic        led;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] count;
        logic [3:0]  exp_gnt;
        int          pulses;
    } vec_t;

    vec_t vecs [5];

    led_code_sequencer #(
        .CLK_HZ  (1000),
        .TICK_HZ (100),
        .N_REQ   (4),
        .CNT_W   (4),
        .ON_T    (2),
        .OFF_T   (3),
        .GAP_T   (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .count (count),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .led   (led)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Advance until a grant shows up; returns the number of cycles it took.
    task automatic wait_gnt(input string tag, output int steps);
        steps = 0;
        do begin
            step();
            steps++;
        end while (gnt === 4'b0000 && steps < 50);
        check({tag, " gnt_arrived"}, 32'(gnt !== 4'b0000), 32'd1);
    endtask

    // Called at the first sample showing gnt; follows the code to its done pulse.
    task automatic run_code(input string tag, input logic [3:0] exp_gnt,
                            input int pulses, input bit mutate);
        int   busy_cyc;
        int   falls;
        int   bad_run;
        int   extra;
        int   run;
        logic prev;
        check({tag, " gnt"}, 32'(gnt), 32'(exp_gnt));
        check({tag, " led_on_at_grant"}, 32'(led), 32'd0);
        check({tag, " busy_at_grant"}, 32'(busy), 32'd1);
        if (mutate) begin
            req   = 4'b0000;
            count = 16'h9999;
        end
        busy_cyc = 0;
        falls    = 1;
        bad_run  = 0;
        extra    = 0;
        run      = 0;
        prev     = 1'b0;
        while (busy === 1'b1 && busy_cyc < 2000) begin
            busy_cyc++;
            if (busy_cyc > 1 && gnt !== 4'b0000) extra++;
            if (done !== 1'b0) extra++;
            if (led === prev) begin
                run++;
            end else begin
                if (prev == 1'b0 && run != ON_C) bad_run++;
                if (prev == 1'b1 && run != OFF_C) bad_run++;
                if (led == 1'b0) falls++;
                run  = 1;
                prev = led;
            end
            step();
        end
        check({tag, " busy_cycles"}, 32'(busy_cyc),
              32'(pulses * ON_C + (pulses - 1) * OFF_C + GAP_C));
        check({tag, " pulses"}, 32'(falls), 32'(pulses));
        check({tag, " phase_lengths"}, 32'(bad_run), 32'd0);
        check({tag, " gap_length"}, 32'(run), 32'(GAP_C));
        check({tag, " stray_gnt_done"}, 32'(extra), 32'd0);
        check({tag, " done_at_end"}, 32'(done), 32'd1);
        check({tag, " led_off_at_end"}, 32'(led), 32'd1);
    endtask

    initial begin
        int       steps;
        int       stray;
        logic [3:0] rr_order [4];

        // rr pointer walk: 0 -> grant1 ->2 -> grant2 ->3 -> grant0 ->1 -> grant0 ->1 -> grant2 ->3
        vecs[0] = '{req: 4'b0010, count: 16'h0030, exp_gnt: 4'b0010, pulses: 3};
        vecs[1] = '{req: 4'b1111, count: 16'h1411, exp_gnt: 4'b0100, pulses: 4};
        vecs[2] = '{req: 4'b0011, count: 16'h0021, exp_gnt: 4'b0001, pulses: 1};
        vecs[3] = '{req: 4'b1001, count: 16'h000F, exp_gnt: 4'b0001, pulses: 15};
        vecs[4] = '{req: 4'b0101, count: 16'h0900 | 16'h0200 & 16'h0F00, exp_gnt: 4'b0100, pulses: 2};
        vecs[4].count = 16'h0200;

        rst_n = 1'b0;
        req   = 4'b0000;
        count = 16'h0000;
        #12;
        check("reset led", 32'(led), 32'd1);
        check("reset gnt", 32'(gnt), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        #11 rst_n = 1'b1;
        step();

        // Table: each code requested from IDLE, inputs scrambled during the first ON.
        for (int i = 0; i < 5; i++) begin
            req   = vecs[i].req;
            count = vecs[i].count;
            wait_gnt($sformatf("vec%0d", i), steps);
            check($sformatf("vec%0d gnt_latency", i), 32'(steps), 32'd1);
            run_code($sformatf("vec%0d", i), vecs[i].exp_gnt, vecs[i].pulses, 1'b1);
        end

        // A zero-count request alone never gets granted.
        req   = 4'b0001;
        count = 16'h0000;
        stray = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (gnt !== 4'b0000 || busy !== 1'b0) stray++;
        end
        check("zero_count never_granted", 32'(stray), 32'd0);

        // Reset during OFF, then requester 3 is granted from a cleared pointer.
        req   = 4'b0010;
        count = 16'h0030;
        wait_gnt("rst_pre", steps);
        check("rst_pre gnt", 32'(gnt), 32'b0010);
        for (int i = 0; i < 25; i++) step();
        check("rst_pre in_off led", 32'(led), 32'd1);
        check("rst_pre in_off busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async led", 32'(led), 32'd1);
        check("rst_async busy", 32'(busy), 32'd0);
        check("rst_async gnt", 32'(gnt), 32'd0);
        req   = 4'b1000;
        count = 16'h1000;
        stray = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done !== 1'b0) stray++;
        end
        check("rst_held no_done", 32'(stray), 32'd0);
        #2 rst_n = 1'b1;
        wait_gnt("rst_post", steps);
        run_code("rst_post", 4'b1000, 1, 1'b1);

        // Simultaneous held requests, rr pointer at 0: served 0,1,3,0 back to back.
        rr_order[0] = 4'b0001;
        rr_order[1] = 4'b0010;
        rr_order[2] = 4'b1000;
        rr_order[3] = 4'b0001;
        req   = 4'b1011;
        count = 16'h1111;
        for (int i = 0; i < 4; i++) begin
            wait_gnt($sformatf("rr%0d", i), steps);
            check($sformatf("rr%0d gnt_after_done", i), 32'(steps), 32'd1);
            run_code($sformatf("rr%0d", i), rr_order[i], 1, (i == 3));
        end
        step();
        check("final idle busy", 32'(busy), 32'd0);
        check("final done_one_cycle", 32'(done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
